mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_pkg.sv | 21 ++
 rtl/data_ram.sv | 40 ++++
 rtl/mem_stage.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the MEM pipeline stage.
package mem_pkg;

    // Memory-access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit positions inside the M control field
    localparam int unsigned M_READ  = 1;
    localparam int unsigned M_WRITE = 0;

    // Default memory wait cycles per access (legal 1..15)
    localparam int unsigned WAIT_CYC_DEFAULT = 2;

    // Wait counter width, enough for the largest legal WAIT_CYC
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/data_ram.sv
// data_ram: single-port synchronous data RAM, 2^DEPTH_LOG2 x 32.
// Array contents are never reset; only the registered read port is.
module data_ram
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Write port: commit on the access edge only
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Registered read data; holds its value between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a multi-cycle data memory.
// Stalls upstream for WAIT_CYC+1 cycles per load/store, then a DONE cycle.
// Optional feature: define MEM_STALL_CNT_EN to add a saturating stall_cnt
// output counting stall-high cycles.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYC   = WAIT_CYC_DEFAULT,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_in,
    input  logic [1:0]  WB_in,
    input  logic [1:0]  M_in,
    input  logic [31:0] ALU_in,
    input  logic [31:0] WD_in,
    input  logic [4:0]  WN_in,
    output logic [1:0]  WB_out,
    output logic [31:0] RD_out,
    output logic [31:0] ADDR_out,
    output logic [4:0]  WN_out,
    output logic        stall
`ifdef MEM_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_raw;
    logic               ram_we, ram_re;
    logic [31:0]        rd_q;
    logic [DEPTH_LOG2-1:0] word;

    // Byte address to word index; upper bits dropped so addresses wrap
    assign word = ALU_in[DEPTH_LOG2+1:2];

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, stall and RAM strobes
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_in && (M_in != 2'b00)) begin
                    stall_raw = 1'b1;
                    cnt_d     = CNT_W'(WAIT_CYC - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                stall_raw = 1'b1;
                if (cnt_q == '0) begin
                    // Read-modify combos (M=11) perform the write only
                    ram_we  = M_in[M_WRITE];
                    ram_re  = M_in[M_READ] & ~M_in[M_WRITE];
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset must drop stall at once, even while the IDLE decode sees a request
    assign stall = stall_raw & rst;

    data_ram #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (word),
        .wdata (WD_in),
        .rdata (rd_q)
    );

    assign RD_out   = rd_q;
    assign ADDR_out = ALU_in;
    assign WN_out   = WN_in;
    assign WB_out   = (en_in && !stall) ? WB_in : 2'b00;

`ifdef MEM_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of stall-high cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
